// File: rtl/ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// ram_access_arbiter
//
// Shares one single-port RAM between the fetch stage (IF, read-only) and the
// memory stage (MEM, load/store). Every access runs IDLE -> ISSUE ->
// (WAIT x RAM_LATENCY for reads) -> RESP -> IDLE. The requester that is not
// being served sees its stall asserted.
//
// Handshake: a requester raises req (if_req_i, or mem_re_i/mem_we_i) together
// with address/data and holds it until its done pulse. done is high for
// exactly one cycle. Read data is valid while done=1 and is held afterwards.
// Requests are sampled only in IDLE. A req still high in the IDLE cycle after
// done counts as a new request. Dropping req mid-access does not cancel it.
//
// Optional feature (macro RAM_ARB_RR_EN):
//   defined   - round-robin on ties using a last_owner register (reset = IF)
//   undefined - fixed priority, MEM always wins
//
// Ports:
//   clk_i, resetn_i           clock, synchronous active-low reset
//   if_req_i, if_addr_i       fetch read request and address
//   if_rdata_o, if_done_o     fetch read data and completion pulse
//   if_stall_o                if_req_i & ~if_done_o
//   mem_re_i, mem_we_i        load / store request (both high = store)
//   mem_addr_i, mem_wdata_i   load/store address and store data
//   mem_rdata_o, mem_done_o   load data and completion pulse
//   mem_stall_o               (mem_re_i | mem_we_i) & ~mem_done_o
//   ram_en_o, ram_we_o        RAM strobe (one cycle per access), write enable
//   ram_addr_o, ram_wdata_o   RAM address and write data (hold last value)
//   ram_rdata_i               RAM read data, valid RAM_LATENCY after ram_en_o
//   dbg_state_o               current FSM state for debug/observation
// -----------------------------------------------------------------------------
module ram_access_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  output logic              mem_stall_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                owner_mem_q, owner_mem_d;   // 1 = MEM owns the access
  logic                is_write_q, is_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic                mem_pend;
  logic                any_pend;
  logic                grant_mem;

  assign mem_pend = mem_re_i | mem_we_i;
  assign any_pend = mem_pend | if_req_i;

`ifdef RAM_ARB_RR_EN
  logic last_mem_q, last_mem_d;
  // On a tie, serve whoever did not get the previous grant.
  assign grant_mem = mem_pend & (~if_req_i | ~last_mem_q);
`else
  assign grant_mem = mem_pend;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      owner_mem_q <= 1'b0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef RAM_ARB_RR_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef RAM_ARB_RR_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef RAM_ARB_RR_EN
    last_mem_d  = last_mem_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          owner_mem_d = grant_mem;
          // mem_we_i wins over mem_re_i when both are high.
          is_write_d  = grant_mem & mem_we_i;
          addr_d      = grant_mem ? mem_addr_i : if_addr_i;
          // IF never writes, so the write-data register is left alone for it.
          if (grant_mem) begin
            wdata_d = mem_wdata_i;
          end
`ifdef RAM_ARB_RR_EN
          last_mem_d  = grant_mem;
`endif
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_write_q) begin
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(RAM_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter value 1 marks the cycle in which ram_rdata_i is valid.
        if (cnt_q == CNT_W'(1)) begin
          if (owner_mem_q) begin
            mem_rdata_d = ram_rdata_i;
          end else begin
            if_rdata_d = ram_rdata_i;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    ram_en_o    = (state_q == ST_ISSUE);
    ram_we_o    = (state_q == ST_ISSUE) & is_write_q;
    ram_addr_o  = addr_q;
    ram_wdata_o = wdata_q;
    if_done_o   = (state_q == ST_RESP) & ~owner_mem_q;
    mem_done_o  = (state_q == ST_RESP) & owner_mem_q;
    if_rdata_o  = if_rdata_q;
    mem_rdata_o = mem_rdata_q;
    if_stall_o  = if_req_i & ~((state_q == ST_RESP) & ~owner_mem_q);
    mem_stall_o = mem_pend & ~((state_q == ST_RESP) & owner_mem_q);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
`timescale 1ns/1ps
module tb_ram_access_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          if_req_i, mem_re_i, mem_we_i;
  logic [AW-1:0] if_addr_i, mem_addr_i;
  logic [DW-1:0] mem_wdata_i, ram_rdata_i;
  logic [DW-1:0] if_rdata_o, mem_rdata_o, ram_wdata_o;
  logic [AW-1:0] ram_addr_o;
  logic          if_done_o, if_stall_o, mem_done_o, mem_stall_o, ram_en_o, ram_we_o;
  logic [1:0]    dbg_state_o;

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .mem_stall_o(mem_stall_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // RAM macro model driven by the DUT's RAM port
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t rd_q[$];

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : ~a;
  endfunction

  always @(negedge clk) begin
    if (!resetn) rd_q.delete();
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] = ram_wdata_o;
      else rd_q.push_back('{due: cyc + LAT, data: ram_rd(ram_addr_o)});
    end
  end

  always @(posedge clk) begin
    #1;
    ram_rdata_i = 32'hBAD0_0000 ^ 32'(cyc);
    while (rd_q.size() != 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
    foreach (rd_q[i]) if (rd_q[i].due == cyc) ram_rdata_i = rd_q[i].data;
  end

  // Transaction-level model: a grant in IDLE cycle c schedules ram_en at c+1
  // and done at c+2 (write) or c+2+LAT (read); IDLE resumes after done.
  logic [DW-1:0] shadow [logic [AW-1:0]];
  function automatic logic [DW-1:0] shd_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : ~a;
  endfunction

  bit            m_busy = 1'b0, m_mem = 1'b0, m_wr = 1'b0, m_last_mem = 1'b0;
  int            m_en_c = 0, m_done_c = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, e_if_rdata = '0, e_mem_rdata = '0;

  always @(negedge clk) begin
    bit e_en, e_if_done, e_mem_done, pick_mem;
    e_en       = m_busy && (cyc == m_en_c);
    e_if_done  = m_busy && (cyc == m_done_c) && !m_mem;
    e_mem_done = m_busy && (cyc == m_done_c) && m_mem;
    check("ram_en", ram_en_o, e_en);
    check("ram_we", ram_we_o, e_en && m_wr);
    check("ram_addr", ram_addr_o, m_addr);
    check("ram_wdata", ram_wdata_o, m_wdata);
    check("if_done", if_done_o, e_if_done);
    check("mem_done", mem_done_o, e_mem_done);
    check("if_rdata", if_rdata_o, e_if_rdata);
    check("mem_rdata", mem_rdata_o, e_mem_rdata);
    check("if_stall", if_stall_o, if_req_i && !e_if_done);
    check("mem_stall", mem_stall_o, (mem_re_i || mem_we_i) && !e_mem_done);

    // The RAM sees the write strobe even if reset lands in the same cycle.
    if (e_en && m_wr) shadow[m_addr] = m_wdata;
    if (!resetn) begin
      m_busy = 0; m_addr = '0; m_wdata = '0;
      e_if_rdata = '0; e_mem_rdata = '0; m_last_mem = 0;
    end else if (m_busy) begin
      if (!m_wr && cyc == m_done_c - 1) begin
        if (m_mem) e_mem_rdata = shd_rd(m_addr);
        else       e_if_rdata  = shd_rd(m_addr);
      end
      if (cyc == m_done_c) m_busy = 0;
    end else if (mem_re_i || mem_we_i || if_req_i) begin
`ifdef RAM_ARB_RR_EN
      pick_mem = (mem_re_i || mem_we_i) && !(if_req_i && m_last_mem);
`else
      pick_mem = mem_re_i || mem_we_i;
`endif
      m_mem    = pick_mem;
      m_wr     = pick_mem && mem_we_i;
      m_addr   = pick_mem ? mem_addr_i : if_addr_i;
      if (pick_mem) m_wdata = mem_wdata_i;
      m_en_c   = cyc + 1;
      m_done_c = cyc + 2 + (m_wr ? 0 : LAT);
      m_busy   = 1;
      m_last_mem = pick_mem;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input bit for_mem, output int en_c, output int done_c);
    en_c = -1; done_c = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ram_en_o && en_c < 0) en_c = cyc;
      if (for_mem ? mem_done_o : if_done_o) begin
        done_c = cyc;
        break;
      end
    end
  endtask

  task automatic mem_access(input bit re, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output int en_l, output int done_l);
    int k, en_c, done_c;
    tick(); k = cyc;
    mem_re_i = re; mem_we_i = we; mem_addr_i = a; mem_wdata_i = wd;
    wait_done(1'b1, en_c, done_c);
    tick(); mem_re_i = 0; mem_we_i = 0;
    en_l = en_c - k; done_l = done_c - k;
  endtask

  initial begin
    int k, en_l, done_l, ifd, md, enn;
    logic [AW-1:0] en_addr;
    resetn = 0; if_req_i = 1; if_addr_i = '0;
    mem_re_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0;
    ram_mem[32'h40] = 32'hDEAD_BEEF; shadow[32'h40] = 32'hDEAD_BEEF;

    // reset held 3 cycles with if_req high
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ram_en", ram_en_o, 0);
    check("rst_if_done", if_done_o, 0);
    check("rst_mem_done", mem_done_o, 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_mem_rdata", mem_rdata_o, 0);
    tick(); resetn = 1; if_req_i = 0;

    // IF read of 0x40
    tick(); k = cyc; if_req_i = 1; if_addr_i = 32'h40;
    wait_done(1'b0, en_l, done_l);
    tick(); if_req_i = 0;
    check("if_rd_en_cycle", en_l - k, 1);
    check("if_rd_done_cycle", done_l - k, 5);
    check("if_rd_data", if_rdata_o, 32'hDEAD_BEEF);

    // MEM store, then load back
    mem_access(0, 1, 32'h100, 32'h1234_5678, en_l, done_l);
    check("st_en_cycle", en_l, 1);
    check("st_done_cycle", done_l, 2);
    check("st_rdata_kept", mem_rdata_o, 0);
    mem_access(1, 0, 32'h100, 32'h0, en_l, done_l);
    check("ld_en_cycle", en_l, 1);
    check("ld_done_cycle", done_l, 5);
    check("ld_data", mem_rdata_o, 32'h1234_5678);
    check("ld_if_rdata_kept", if_rdata_o, 32'hDEAD_BEEF);

    // re and we together behave as a store
    mem_access(1, 1, 32'h200, 32'hA5A5_0F0F, en_l, done_l);
    check("rw_done_cycle", done_l, 2);
    check("rw_rdata_kept", mem_rdata_o, 32'h1234_5678);
    mem_access(1, 0, 32'h200, 32'h0, en_l, done_l);
    check("rw_readback", mem_rdata_o, 32'hA5A5_0F0F);

    // contention from a fresh reset
    tick(); resetn = 0;
    tick(); resetn = 1;
    tick(); if_req_i = 1; if_addr_i = 32'h40; mem_re_i = 1; mem_addr_i = 32'h100;
    ifd = 0; md = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (if_done_o) ifd++;
      if (mem_done_o) md++;
      tick();
    end
    if_req_i = 0; mem_re_i = 0;
`ifdef RAM_ARB_RR_EN
    check("tie_mem_dones", md, 2);
    check("tie_if_dones", ifd, 1);
`else
    check("tie_mem_dones", md, 3);
    check("tie_if_dones", ifd, 0);
`endif

    // reset during WAIT
    tick(); resetn = 0;
    tick(); resetn = 1;
    tick(); k = cyc; if_req_i = 1; if_addr_i = 32'h100;
    tick(); if_req_i = 0;
    tick();
    tick(); resetn = 0;
    tick(); resetn = 1;
    @(negedge clk);
    check("rstw_ram_en", ram_en_o, 0);
    check("rstw_if_rdata", if_rdata_o, 0);
    ifd = (if_done_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (if_done_o) ifd++;
    end
    check("rstw_no_done", ifd, 0);
    check("rstw_mem_rdata", mem_rdata_o, 0);

    // requester drops req and changes address after ISSUE
    tick(); k = cyc; mem_re_i = 1; mem_addr_i = 32'h100;
    enn = 0; md = 0; done_l = -1; en_addr = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ram_en_o) begin enn++; en_addr = ram_addr_o; end
      if (mem_done_o) begin md++; done_l = cyc - k; end
      tick();
      if (i == 1) begin mem_re_i = 0; mem_addr_i = 32'h300; end
    end
    check("drop_en_count", enn, 1);
    check("drop_en_addr", en_addr, 32'h100);
    check("drop_done_count", md, 1);
    check("drop_done_cycle", done_l, 5);
    check("drop_data", mem_rdata_o, 32'h1234_5678);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
